imem_loader: RTL and testbench

Instruction-memory writer: accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words into a 256×32 instruction store at consecutive addresses starting at 0. The store also provides the asynchronous `pc -> ins` read port consumed by the fetch stage, so it replaces file-based preloading with run-time program loading.

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_ram.sv | 17 +
 rtl/imem_loader.sv | 67 ++++++
 tb/tb_imem_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared widths and loader state encoding for the instruction store
package imem_pkg;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: instruction store with one synchronous write port and one asynchronous read port
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into words written at consecutive store addresses
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              start,
  input  logic [ADDR_W-1:0] nwords,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ins
);
  loader_state_t r_state, w_next;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_byte_cnt;
  logic [DATA_W-9:0] r_asm;
  logic              w_start, w_accept, w_we;
  always_comb begin
    w_start  = start & (r_state != LOAD);
    w_accept = byte_valid & (r_state == LOAD);
    w_we     = w_accept & (r_byte_cnt == 2'd3);
    w_next   = w_start ? LOAD : (w_we && r_remaining == (ADDR_W+1)'(1)) ? DONE : r_state;
  end
  always_ff @(posedge clk)
    if (!rstd) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_wr_addr   <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_remaining <= {nwords == '0, nwords};
        r_wr_addr   <= '0;
        r_byte_cnt  <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_asm      <= {r_asm[DATA_W-17:0], byte_in};
        if (w_we) begin
          r_wr_addr   <= r_wr_addr + ADDR_W'(1);
          r_remaining <= r_remaining - (ADDR_W+1)'(1);
        end
      end
    end
  assign byte_ready = r_state == LOAD;
  assign busy       = r_state == LOAD;
  assign done       = r_state == DONE;
  assign wr_addr    = r_wr_addr;
  imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_addr),
    .wdata ({r_asm, byte_in}),
    .raddr (pc),
    .rdata (ins)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads scored against a word-level memory model
module tb_imem_loader;
  logic        clk = 0;
  logic        rstd = 0;
  logic        start = 0;
  logic [7:0]  nwords = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_valid = 0;
  logic        byte_ready, busy, done;
  logic [7:0]  wr_addr;
  logic [7:0]  pc = 0;
  logic [31:0] ins;
  typedef struct packed {
    logic [7:0]  addr;
    logic        has_old;
    logic [31:0] old;
    logic [31:0] neu;
  } exp_t;
  exp_t        expq[$];
  logic [7:0]  fixq[$];
  logic [31:0] mdl [256];
  logic        written [256];
  logic        sweep_req = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  imem_loader dut (
    .clk(clk), .rstd(rstd), .start(start), .nwords(nwords), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done),
    .wr_addr(wr_addr), .pc(pc), .ins(ins)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_ready"}, 32'(byte_ready), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_wr_addr"}, 32'(wr_addr), 0);
  endtask
  task automatic run_load(input int n, input int mode, input int abort_at, input int pulse_at);
    int words, target, acc, cyc, addr;
    logic [7:0] b;
    logic have;
    logic [7:0] got[$];
    exp_t e;
    words = (n == 0) ? 256 : n;
    target = (abort_at >= 0) ? abort_at : words * 4;
    start = 1;
    nwords = 8'(n);
    @(negedge clk);
    start = 0;
    nwords = 8'($urandom);
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_wr_addr", 32'(wr_addr), 0);
    acc = 0;
    cyc = 0;
    have = 0;
    b = 0;
    while (acc < target && cyc < target * 8 + 64) begin
      if (!have) begin
        b = (fixq.size() != 0) ? fixq.pop_front() : 8'($urandom);
        have = 1;
      end
      byte_in = b;
      byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      start = (acc == pulse_at);
      nwords = 8'($urandom);
      chk("load_ready", 32'(byte_ready), 1);
      if (byte_valid && byte_ready) begin
        have = 0;
        acc++;
        got.push_back(b);
        if (acc % 4 == 0) begin
          addr = (acc / 4 - 1) % 256;
          e.addr = 8'(addr);
          e.has_old = written[addr];
          e.old = mdl[addr];
          e.neu = {got[acc-4], got[acc-3], got[acc-2], got[acc-1]};
          expq.push_back(e);
          mdl[addr] = e.neu;
          written[addr] = 1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    byte_valid = 0;
    start = 0;
    chk("bytes_accepted", 32'(acc), 32'(target));
    if (abort_at < 0) begin
      chk("end_done", 32'(done), 1);
      chk("end_busy", 32'(busy), 0);
      chk("end_ready", 32'(byte_ready), 0);
      chk("end_wr_addr", 32'(wr_addr), 32'(words % 256));
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sweep_req) begin
        for (int a = 0; a < 256; a++)
          if (written[a]) begin
            pc = 8'(a);
            #1;
            chk("sweep_ins", ins, mdl[a]);
          end
        sweep_req = 0;
      end else if (expq.size() != 0) begin
        e = expq[0];
        pc = e.addr;
        #1;
        if (e.has_old) chk("ins_before_write", ins, e.old);
        @(posedge clk);
        #1;
        chk("ins_after_write", ins, e.neu);
        void'(expq.pop_front());
      end
    end
  end
  initial begin
    for (int a = 0; a < 256; a++) begin
      mdl[a] = 'x;
      written[a] = 0;
    end
    start = 1;
    nwords = 5;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rstd = 1;
    start = 0;
    @(negedge clk);
    chk_idle("reset_beats_start");
    fixq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(2, 0, -1, -1);
    @(negedge clk);
    chk("done_sticky", 32'(done), 1);
    fixq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(2, 1, -1, -1);
    run_load(2, 0, 6, -1);
    rstd = 0;
    @(negedge clk);
    rstd = 1;
    chk_idle("mid_load_reset");
    fixq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, -1, -1);
    for (int i = 0; i < 3; i++) run_load(int'($urandom_range(1, 6)), 2, -1, -1);
    run_load(3, 0, -1, 5);
    run_load(0, 0, -1, -1);
    run_load(1, 2, -1, -1);
    repeat (3) @(negedge clk);
    sweep_req = 1;
    for (int i = 0; i < 200 && sweep_req; i++) @(negedge clk);
    chk("sweep_timeout", 32'(sweep_req), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
